bcd_xs3_seq_ctrl: RTL and testbench
===================================

Name: bcd_xs3_seq_ctrl

Overview:
Sequencing controller for a multi-digit BCD-to-excess-3 conversion.
- Accepts a packed multi-digit BCD word over a valid/ready handshake.
- Time-shares one single-digit converter across all digits, one digit per clock, LSB digit first.
- Presents the packed excess-3 result with per-digit invalid-BCD flags over a valid/ready handshake.
- Sits between a BCD producer (keypad/counter front end) and any excess-3 consumer.

Parameters:
DIGITS, 4, number of BCD digits per word (1..8)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word on in_bcd
in_ready  output  1  controller can accept a word
in_bcd  input  4*DIGITS  packed BCD, digit k at bits [4k+3:4k]
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_xs3  output  4*DIGITS  packed excess-3 result, same digit layout
out_err  output  1  OR of out_err_mask
out_err_mask  output  DIGITS  bit k set when input digit k was > 9
busy  output  1  high in CONV or DONE

Behaviour:
Interface decision:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Reset values:
- State IDLE.
- in_ready=0, out_valid=0, busy=0.
- out_xs3=0, out_err=0, out_err_mask=0.
- Digit index=0; capture register=0.
- in_ready rises on the first clk edge after rst_n deasserts. It is a registered output.

FSM states: IDLE, CONV, DONE.

IDLE:
- in_ready=1.
- On in_valid & in_ready at edge E0:
  - latch in_bcd into capture register
  - clear result and mask registers
  - idx=0, in_ready<=0, busy<=1
  - go to CONV

CONV:
- Each edge converts digit idx and writes result nibble idx and mask bit idx.
- idx increments by 1 each edge.
- When idx==DIGITS-1: out_valid<=1, then go to DONE.
- in_valid is ignored during CONV.

DONE:
- out_valid=1.
- out_xs3, out_err and out_err_mask are held stable until out_ready=1.
- On out_valid & out_ready at an edge: out_valid<=0, busy<=0, in_ready<=1, go to IDLE.
- No overlap between result holding and new input acceptance.

Latency:
- Accept edge E0; digits processed on edges E1..E_DIGITS.
- out_valid is high after edge E_DIGITS, i.e. DIGITS cycles after accept.
- Minimum accept-to-accept period is DIGITS+2 cycles.

Digit arithmetic:
- Valid digit (0..9): xs3 = bcd + 4'd3, 4-bit result, range 0011..1100, no overflow.
- Invalid digit (1010..1111): result nibble 4'b0000, mask bit set.
- No X is ever driven on the outputs.
- out_err = |out_err_mask, registered together with out_valid.

Boundary conditions:
- DIGITS=1: a single CONV cycle.
- in_valid held high across a DONE handshake: the word is not accepted until in_ready=1 in IDLE, one cycle later.
- rst_n asserted in any state aborts immediately:
  - captured word discarded, all outputs return to reset values
  - no partial result is ever presented

Decomposition:
Package bcd_xs3_pkg holds:
- XS3_OFFSET=4'd3
- BCD_MAX=4'd9
- XS3_INVALID=4'b0000
- state enum {IDLE, CONV, DONE}

Sub-module bcd_xs3_digit (combinational):
- Inputs: 4-bit bcd.
- Outputs: 4-bit xs3, 1-bit invalid.
- Instantiated once. The controller muxes capture-register nibble idx into it.

Test Plan:
1. Hold rst_n=0 for 3 cycles, then release. Required: all outputs 0 during reset; in_ready=1 from the cycle after the first post-release edge; busy=0.
2. DIGITS=4, in_bcd=16'h1234, out_ready=1. Required: out_xs3=16'h4567, out_err=0, mask=4'b0000; out_valid high exactly 4 cycles after the accept edge, for one cycle.
3. Send 16'h9050. Required: out_xs3=16'hC383, out_err=0. Then send 16'h12A9. Required: out_xs3=16'h450C, mask=4'b0010, out_err=1.
4. Send 16'h0000 and 16'hFFFF. Required: 16'h3333 with mask 0; 16'h0000 with mask 4'b1111 and out_err=1.
5. Backpressure: send 16'h0987 with out_ready=0 for 6 cycles after out_valid, and pulse in_valid with 16'h1111 during that time. Required:
   - out_xs3=16'h3CBA held stable
   - in_ready=0 and the pulse ignored
   - after out_ready=1, in_ready=1 the next cycle
   - 16'h1111 then converts to 16'h4444
6. Assert rst_n=0 asynchronously mid-CONV (after 2 digit edges) of 16'h5678. Required: outputs drop to 0 immediately, with no out_valid for that word. After release, 16'h0001 yields 16'h3334.

Source files
------------

// File: rtl/bcd_xs3_pkg.sv
// -----------------------------------------------------------------------------
// bcd_xs3_pkg
// Shared constants and types for the multi-digit BCD-to-excess-3 sequencer.
//   XS3_OFFSET  : value added to a legal BCD digit to form its excess-3 code
//   BCD_MAX     : largest legal BCD digit
//   XS3_INVALID : nibble emitted in place of an illegal digit
//   state_e     : controller FSM states
// -----------------------------------------------------------------------------
package bcd_xs3_pkg;

    localparam logic [3:0] XS3_OFFSET  = 4'd3;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] XS3_INVALID = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_xs3_digit.sv
// -----------------------------------------------------------------------------
// bcd_xs3_digit
// Combinational single-digit BCD to excess-3 converter.
// Ports:
//   bcd     in  [3:0]  BCD digit
//   xs3     out [3:0]  excess-3 code, or XS3_INVALID when bcd > 9
//   invalid out        set when bcd is not a legal BCD digit
// -----------------------------------------------------------------------------
module bcd_xs3_digit
    import bcd_xs3_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [3:0] xs3,
    output logic       invalid
);

    always_comb begin
        invalid = (bcd > BCD_MAX);
        // Legal digits map to 0011..1100, so the 4-bit add never overflows.
        xs3     = invalid ? XS3_INVALID : (bcd + XS3_OFFSET);
    end

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_xs3_seq_ctrl
// Converts a packed multi-digit BCD word to excess-3 by time-sharing one
// bcd_xs3_digit converter, one digit per clock, least significant digit first.
// Ports:
//   clk           in                 system clock, rising edge
//   rst_n         in                 asynchronous active-low reset
//   in_valid      in                 producer has a word on in_bcd
//   in_ready      out                controller can accept a word (registered)
//   in_bcd        in  [4*DIGITS-1:0] packed BCD, digit k at [4k+3:4k]
//   out_valid     out                result available (registered)
//   out_ready     in                 consumer accepts result
//   out_xs3       out [4*DIGITS-1:0] packed excess-3 result, same layout
//   out_err       out                OR of out_err_mask
//   out_err_mask  out [DIGITS-1:0]   bit k set when input digit k was > 9
//   busy          out                high while converting or holding a result
// -----------------------------------------------------------------------------
module bcd_xs3_seq_ctrl
    import bcd_xs3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_xs3,
    output logic                  out_err,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  busy
);

    // A one-digit word still needs a 1-bit index register.
    localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_e                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [4*DIGITS-1:0]   cap_q;
    logic [4*DIGITS-1:0]   res_q;
    logic [4*DIGITS-1:0]   res_d;
    logic [DIGITS-1:0]     mask_q;
    logic [DIGITS-1:0]     mask_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic                  err_q;

    logic [3:0]            dig_bcd;
    logic [3:0]            dig_xs3;
    logic                  dig_inv;

    // Select the captured nibble for the digit being processed this cycle.
    assign dig_bcd = cap_q[idx_q*4 +: 4];

    bcd_xs3_digit u_digit (
        .bcd     (dig_bcd),
        .xs3     (dig_xs3),
        .invalid (dig_inv)
    );

    // Result and mask with the current digit merged in.
    always_comb begin
        // NOTE: every always_comb output gets a full default before any
        // conditional or partial update, otherwise a latch is inferred.
        res_d                   = res_q;
        mask_d                  = mask_q;
        res_d[idx_q*4 +: 4]     = dig_xs3;
        mask_d[idx_q]           = dig_inv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the capture and result registers are reset too, so an
            // aborted word can never leak out as stale data after reset.
            state_q     <= IDLE;
            idx_q       <= '0;
            cap_q       <= '0;
            res_q       <= '0;
            mask_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register sees the pre-edge values of the others.
            unique case (state_q)
                IDLE: begin
                    // in_ready comes up one edge after reset release.
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        cap_q      <= in_bcd;
                        res_q      <= '0;
                        mask_q     <= '0;
                        err_q      <= 1'b0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    res_q  <= res_d;
                    mask_q <= mask_d;
                    if (idx_q == IDX_LAST) begin
                        // Error flag is registered together with out_valid.
                        out_valid_q <= 1'b1;
                        err_q       <= |mask_d;
                        idx_q       <= '0;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it; no new input
                    // is accepted while a result is pending.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign out_xs3      = res_q;
    assign out_err_mask = mask_q;
    assign out_err      = err_q;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_xs3_seq_ctrl
// Self-checking bench for bcd_xs3_seq_ctrl with DIGITS=4. Expected results are
// queued when a word is accepted and compared by a monitor when the result
// handshake happens.
// -----------------------------------------------------------------------------
module tb_bcd_xs3_seq_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_bcd;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_xs3;
    logic              out_err;
    logic [DIGITS-1:0] out_err_mask;
    logic              busy;

    typedef struct {
        logic [W-1:0]      bcd;
        logic [W-1:0]      xs3;
        logic [DIGITS-1:0] mask;
    } vec_t;

    typedef struct {
        logic [W-1:0]      xs3;
        logic [DIGITS-1:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bcd_xs3_seq_ctrl #(.DIGITS(DIGITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bcd       (in_bcd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_xs3      (out_xs3),
        .out_err      (out_err),
        .out_err_mask (out_err_mask),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: legal digit + 3, illegal digit -> 0 with mask bit.
    function automatic exp_t model(input logic [W-1:0] bcd);
        exp_t       e;
        logic [3:0] d;
        e.xs3  = '0;
        e.mask = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d = bcd[k*4 +: 4];
            if (d > 4'd9) e.mask[k] = 1'b1;
            else          e.xs3[k*4 +: 4] = d + 4'd3;
        end
        return e;
    endfunction

    // Scoreboard monitor: samples 2 time units after the falling edge, when
    // inputs and outputs are stable for the next rising edge.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h with no queued expectation", out_xs3);
            end else begin
                e = sb_q.pop_front();
                check("out_xs3",      32'(out_xs3),      32'(e.xs3));
                check("out_err_mask", 32'(out_err_mask), 32'(e.mask));
                check("out_err",      32'(out_err),      32'(|e.mask));
            end
        end
    end

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        if (out_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_valid_timeout: got no out_valid after %0d cycles, expected within %0d", cnt, budget);
        end
    endtask

    // Send one word with out_ready=1; in_valid stays high with different data
    // during conversion to show it is ignored and the captured word is used.
    task automatic run_word(input logic [W-1:0] bcd, input logic [W-1:0] xs3, input logic [DIGITS-1:0] mask);
        exp_t e;
        int   cnt;
        @(negedge clk);
        check("ready_before_send", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bcd    = bcd;
        @(posedge clk);
        e.xs3  = xs3;
        e.mask = mask;
        sb_q.push_back(e);
        @(negedge clk);
        check("busy_after_accept",  32'(busy),     32'd1);
        check("ready_after_accept", 32'(in_ready), 32'd0);
        in_bcd = ~bcd;
        wait_valid(DIGITS + 8, cnt);
        check("latency", 32'(cnt), 32'(DIGITS));
        in_valid = 1'b0;
        @(negedge clk);
        check("valid_one_cycle",   32'(out_valid), 32'd0);
        check("ready_after_done",  32'(in_ready),  32'd1);
        check("idle_not_busy",     32'(busy),      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        exp_t e;
        vec_t rv;
        int   cnt;

        vecs[0] = '{bcd: 16'h1234, xs3: 16'h4567, mask: 4'b0000};
        vecs[1] = '{bcd: 16'h9050, xs3: 16'hC383, mask: 4'b0000};
        vecs[2] = '{bcd: 16'h12A9, xs3: 16'h450C, mask: 4'b0010};
        vecs[3] = '{bcd: 16'h0000, xs3: 16'h3333, mask: 4'b0000};
        vecs[4] = '{bcd: 16'hFFFF, xs3: 16'h0000, mask: 4'b1111};

        // Reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_out_xs3", 32'(out_xs3),      32'd0);
            check("rst_flags",   32'({in_ready, out_valid, busy, out_err}), 32'd0);
            check("rst_mask",    32'(out_err_mask), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(in_ready), 32'd1);
        check("busy_after_release",  32'(busy),     32'd0);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            run_word(vecs[i].bcd, vecs[i].xs3, vecs[i].mask);
        end

        // Random words, including illegal digits
        for (int i = 0; i < 6; i++) begin
            rv.bcd = W'($urandom);
            e      = model(rv.bcd);
            run_word(rv.bcd, e.xs3, e.mask);
        end

        // Backpressure with an ignored in_valid pulse
        @(negedge clk);
        check("bp_ready_before", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bcd    = 16'h0987;
        @(posedge clk);
        e.xs3  = 16'h3CBA;
        e.mask = 4'b0000;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(DIGITS + 8, cnt);
        check("bp_latency", 32'(cnt), 32'(DIGITS));
        for (int i = 0; i < 6; i++) begin
            check("bp_xs3_stable", 32'(out_xs3),   32'h3CBA);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_ready_low",  32'(in_ready),  32'd0);
            in_valid = (i == 2);
            in_bcd   = 16'h1111;
            @(negedge clk);
        end
        check("bp_xs3_final", 32'(out_xs3), 32'h3CBA);
        // in_valid held high across the result handshake
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bcd    = 16'h1111;
        @(negedge clk);
        check("bp_ready_after_hs", 32'(in_ready),  32'd1);
        check("bp_valid_after_hs", 32'(out_valid), 32'd0);
        check("bp_not_accepted",   32'(busy),      32'd0);
        @(posedge clk);
        e.xs3  = 16'h4444;
        e.mask = 4'b0000;
        sb_q.push_back(e);
        @(negedge clk);
        check("bp_accept_busy",  32'(busy),     32'd1);
        check("bp_accept_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_valid(DIGITS + 8, cnt);
        check("bp2_latency", 32'(cnt), 32'(DIGITS));
        @(negedge clk);

        // Asynchronous reset mid-conversion
        @(negedge clk);
        in_valid = 1'b1;
        in_bcd   = 16'h5678;
        @(posedge clk);
        e = model(16'h5678);
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("abort_out_xs3", 32'(out_xs3),      32'd0);
        check("abort_flags",   32'({in_ready, out_valid, busy, out_err}), 32'd0);
        check("abort_mask",    32'(out_err_mask), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_valid_after", 32'(out_valid), 32'd0);
        run_word(16'h0001, 16'h3334, 4'b0000);

        @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
